// File: rtl/axis_pkt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axis_pkt_pkg
// Purpose  : Shared types and default widths for the AXIS packet transmitter
//            and the stream FIFO benches that use it as a traffic source.
// Contents : tx_state_t      - transmitter FSM state encoding
//            C_WIDTH/C_LEN_W/C_CNT_W - default data, length, counter widths
// Revision : 1.0 - initial release
// ============================================================================
package axis_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_t;

  localparam int C_WIDTH = 8;
  localparam int C_LEN_W = 8;
  localparam int C_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/axis_pkt_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_pkt_tx_if
// Purpose  : Command channel plus AXI-Stream master channel of axis_pkt_tx.
// Signals  : Cmd_Valid/Cmd_Len/Cmd_Seed/Cmd_Ready - packet command handshake
//            Gap_Len  - inter-packet gap (only with AXIS_PKT_TX_GAP_EN)
//            M_TData/M_TValid/M_TLast/M_TReady - outgoing stream
// Modports : master - the transmitter view
//            slave  - the command source / stream sink view
// Options  : `define AXIS_PKT_TX_GAP_EN adds the Gap_Len signal
// Revision : 1.0 - initial release
// ============================================================================
interface axis_pkt_tx_if
  import axis_pkt_pkg::*;
#(
  parameter int WIDTH = C_WIDTH,
  parameter int LEN_W = C_LEN_W
);
  logic             Cmd_Valid;
  logic [LEN_W-1:0] Cmd_Len;
  logic [WIDTH-1:0] Cmd_Seed;
  logic             Cmd_Ready;
`ifdef AXIS_PKT_TX_GAP_EN
  logic [7:0]       Gap_Len;
`endif
  logic [WIDTH-1:0] M_TData;
  logic             M_TValid;
  logic             M_TLast;
  logic             M_TReady;

  modport master (
    input  Cmd_Valid, Cmd_Len, Cmd_Seed,
`ifdef AXIS_PKT_TX_GAP_EN
    input  Gap_Len,
`endif
    output Cmd_Ready,
    output M_TData, M_TValid, M_TLast,
    input  M_TReady
  );

  modport slave (
    output Cmd_Valid, Cmd_Len, Cmd_Seed,
`ifdef AXIS_PKT_TX_GAP_EN
    output Gap_Len,
`endif
    input  Cmd_Ready,
    input  M_TData, M_TValid, M_TLast,
    output M_TReady
  );
endinterface
`default_nettype wire

// File: rtl/axis_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module   : axis_pkt_tx
// Purpose  : AXI-Stream packet transmitter. Accepts one (length, seed)
//            command at a time and emits that many beats of incrementing
//            payload, TLast on the final beat, honouring TReady backpressure.
// Ports    : CLK, Reset   - clock, synchronous active-high reset
//            tx           - axis_pkt_tx_if.master (command + stream)
//            Busy         - FSM not in IDLE
//            Done         - one-cycle pulse after the last beat handshake
//                           (or after a zero-length command)
//            PktCount     - packets completed, wrapping
//            BeatCount    - beats transferred, wrapping
// Options  : `define AXIS_PKT_TX_GAP_EN adds a Gap_Len-cycle idle GAP state
//            after each packet
// Revision : 1.0 - initial release
// ============================================================================
module axis_pkt_tx
  import axis_pkt_pkg::*;
#(
  parameter int WIDTH = C_WIDTH,
  parameter int LEN_W = C_LEN_W,
  parameter int CNT_W = C_CNT_W
) (
  input  wire             CLK,
  input  wire             Reset,
  axis_pkt_tx_if.master   tx,
  output logic            Busy,
  output logic            Done,
  output logic [CNT_W-1:0] PktCount,
  output logic [CNT_W-1:0] BeatCount
);

  tx_state_t        r_state;
  logic [LEN_W-1:0] r_remaining;
  logic [WIDTH-1:0] r_tdata;
  logic             r_tvalid;
  logic             r_tlast;
  logic             r_done;
  logic [CNT_W-1:0] r_pkt_cnt;
  logic [CNT_W-1:0] r_beat_cnt;
`ifdef AXIS_PKT_TX_GAP_EN
  logic [7:0]       r_gap_cnt;
`endif

  logic w_handshake;
  assign w_handshake = r_tvalid && tx.M_TReady;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_done      <= 1'b0;
      r_pkt_cnt   <= '0;
      r_beat_cnt  <= '0;
`ifdef AXIS_PKT_TX_GAP_EN
      r_gap_cnt   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (tx.Cmd_Valid) begin
`ifdef AXIS_PKT_TX_GAP_EN
            r_gap_cnt <= tx.Gap_Len;
`endif
            // A zero-length command is consumed and completes immediately
            // without touching the stream or the packet counter.
            if (tx.Cmd_Len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_remaining <= tx.Cmd_Len;
              r_tdata     <= tx.Cmd_Seed;
              r_tvalid    <= 1'b1;
              r_tlast     <= (tx.Cmd_Len == LEN_W'(1));
              r_state     <= SEND;
            end
          end
        end

        SEND: begin
          // Data and TLast only move on a handshake, so they stay stable
          // through any number of stall cycles.
          if (w_handshake) begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            if (r_tlast) begin
              r_tvalid  <= 1'b0;
              r_tlast   <= 1'b0;
              r_done    <= 1'b1;
              r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
`ifdef AXIS_PKT_TX_GAP_EN
              r_state   <= (r_gap_cnt != 8'd0) ? GAP : IDLE;
`else
              r_state   <= IDLE;
`endif
            end else begin
              r_tdata     <= r_tdata + WIDTH'(1);
              r_remaining <= r_remaining - LEN_W'(1);
              // Remaining still counts the beat just sent, so 2 means the
              // next beat is the final one.
              r_tlast     <= (r_remaining == LEN_W'(2));
            end
          end
        end

`ifdef AXIS_PKT_TX_GAP_EN
        GAP: begin
          // Entered with the full gap length loaded; the final gap cycle
          // is the one that sees a count of 1.
          r_gap_cnt <= r_gap_cnt - 8'd1;
          if (r_gap_cnt <= 8'd1) begin
            r_state <= IDLE;
          end
        end
`endif

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign tx.Cmd_Ready = (r_state == IDLE);
  assign tx.M_TData   = r_tdata;
  assign tx.M_TValid  = r_tvalid;
  assign tx.M_TLast   = r_tlast;
  assign Busy         = (r_state != IDLE);
  assign Done         = r_done;
  assign PktCount     = r_pkt_cnt;
  assign BeatCount    = r_beat_cnt;

endmodule
`default_nettype wire

// File: doc/axis_pkt_tx.md
Name: axis_pkt_tx

Overview:
- AXI-Stream packet transmitter (master side); drives the S_ port of the team's stream FIFO or any AXIS slave.
- Accepts one packet command (length, seed) at a time and emits that many beats of incrementing payload.
- Asserts TLast on the final beat and fully honours TReady backpressure.
- Serves as the traffic source for FIFO/datapath benches and for on-chip loopback tests.

Parameters:
- width, 8, TData width in bits
- len_w, 8, Cmd_Len width; max packet length is 2^len_w-1 beats
- cnt_w, 16, width of the packet and beat statistics counters

Ports:
- CLK  in  1  clock
- Reset  in  1  synchronous, active-high reset
- Cmd_Valid  in  1  command valid
- Cmd_Len  in  len_w  beats in the packet
- Cmd_Seed  in  width  data value of beat 0
- Cmd_Ready  out  1  command accepted when Cmd_Valid && Cmd_Ready
- M_TData  out  width  stream data
- M_TValid  out  1  stream valid
- M_TLast  out  1  final beat of the packet
- M_TReady  in  1  downstream ready
- Busy  out  1  state != IDLE
- Done  out  1  one-cycle pulse after the last beat handshake
- PktCount  out  cnt_w  packets completed, wraps
- BeatCount  out  cnt_w  beats transferred, wraps

Behaviour:
- Reset (CLK edge with Reset=1): state=IDLE. M_TValid=0, M_TLast=0, M_TData=0, Done=0, PktCount=0, BeatCount=0. Reset overrides everything, including mid-packet; the partial packet is abandoned with no TLast.
- States: IDLE, SEND, and GAP (GAP exists only with the optional feature).
- IDLE:
  - Cmd_Ready=1.
  - On Cmd_Valid with Cmd_Len>=1: latch Remaining=Cmd_Len and M_TData=Cmd_Seed, then go to SEND.
  - M_TValid rises on the cycle after acceptance (1-cycle command-to-data latency).
  - M_TLast=1 on that first beat if Cmd_Len==1.
- Cmd_Len==0: the command is accepted and no beats are sent. Done pulses the next cycle, PktCount is unchanged, and the state stays IDLE.
- SEND:
  - Cmd_Ready=0 and M_TValid=1.
  - A handshake occurs when M_TValid && M_TReady.
  - While M_TValid=1 and M_TReady=0, M_TData and M_TLast hold stable. M_TValid never drops before its handshake.
  - On a non-last handshake: M_TData <= M_TData+1 (mod 2^width, wraps e.g. 0xFF->0x00), Remaining decrements, and M_TLast <= (Remaining==2).
  - On the last handshake (M_TLast=1): M_TValid<=0, M_TLast<=0, Done<=1, PktCount+1, then go to IDLE (or GAP).
- BeatCount increments on every handshake. Both statistics counters wrap at 2^cnt_w.
- Back-to-back traffic: with no GAP, a command accepted in the cycle after Done gives one idle cycle between packets. M_TValid must not depend combinationally on M_TReady.
- Cmd_Valid is ignored while Busy=1; the command is not lost, it simply waits for Cmd_Ready.

Optional Feature:
- Macro: AXIS_PKT_TX_GAP_EN.
- Defined:
  - Adds input Gap_Len[7:0], sampled at command acceptance.
  - After the last beat, the block stays in GAP for Gap_Len cycles with M_TValid=0, Cmd_Ready=0 and Busy=1, then returns to IDLE.
  - Gap_Len==0 skips GAP.
  - Reset during GAP goes straight to IDLE.
- Undefined: no Gap_Len port and no GAP state; the block returns to IDLE directly after the last beat.

Decomposition:
- Package axis_pkt_pkg holds:
  - typedef enum logic [1:0] tx_state_t {IDLE, SEND, GAP}
  - localparam defaults for width, len_w and cnt_w, shared with the FIFO benches
- No sub-module: a single FSM with datapath counters is sufficient.
- The statistics counters may optionally be split into a small axis_stat_cnt sub-module, reusable on the receive side.

Test Plan:
- Cmd_Len=4, Cmd_Seed=0x10, M_TReady=1 -> data 0x10,0x11,0x12,0x13 on consecutive cycles; TLast only on 0x13; Done 1 cycle later; PktCount=1, BeatCount=4.
- Cmd_Len=3, Seed=0xFE, M_TReady toggling 1,0,0,1,... -> data stable during stalls; sequence 0xFE,0xFF,0x00; TLast on 0x00; BeatCount=3.
- Cmd_Len=1, Seed=0x55 -> single beat with TValid=1 and TLast=1 together; Done pulse; Busy back to 0.
- Cmd_Len=0 -> Cmd_Ready accepts, no TValid, Done pulses, PktCount unchanged.
- Cmd_Len=8, Reset asserted after 3 handshakes -> next cycle TValid=0, TLast=0, counters=0, Cmd_Ready=1; a new command runs normally.
- With AXIS_PKT_TX_GAP_EN: two commands, Gap_Len=5 -> exactly 5 cycles with TValid=0 and Cmd_Ready=0 between the first TLast handshake and the return to IDLE.
